// File: rtl/mhsa_pkg.sv
// Shared MHSA memory map, attention geometry and sweep FSM state type.
package mhsa_pkg;

   localparam int unsigned LINEAR_OUTPUT_BASE  = 0;
   localparam int unsigned LINEAR_OUTPUT_SIZE  = 1536;
   localparam int unsigned QKMM_OUTPUT_BASE    = 2048;
   localparam int unsigned SOFTMAX_OUTPUT_BASE = 2560;

   localparam int unsigned NUM_HEADS      = 4;
   localparam int unsigned SEQ_LEN        = 32;
   localparam int unsigned BYTES_PER_WORD = 8;
   localparam int unsigned WORDS_PER_ROW  = SEQ_LEN / BYTES_PER_WORD;
   localparam int unsigned SOFTMAX_WORDS  = NUM_HEADS * SEQ_LEN * WORDS_PER_ROW;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_DONE
   } sm_state_e;

endpackage

// File: rtl/softmax_reader_sync_fifo.sv
// Small synchronous FIFO (power-of-two DEPTH) with occupancy count.
module sync_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q];
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;

endmodule

// File: rtl/softmax_reader.sv
// Sweeps the softmax output region and streams it, tagged, to the AV matmul stage.
// Optional checksum port: define SOFTMAX_READER_CHECKSUM_EN.
module softmax_reader #(
   parameter int unsigned WIDTH               = 64,
   parameter int unsigned SOFTMAX_OUTPUT_BASE = mhsa_pkg::SOFTMAX_OUTPUT_BASE,
   parameter int unsigned NUM_WORDS           = mhsa_pkg::SOFTMAX_WORDS,
   parameter int unsigned WORDS_PER_ROW       = mhsa_pkg::WORDS_PER_ROW,
   parameter int unsigned ROWS_PER_HEAD       = mhsa_pkg::SEQ_LEN,
   parameter int unsigned FIFO_DEPTH          = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              done,
   output logic              busy,
   output logic              write_en_bar,
   output logic [WIDTH-1:0]  data_in_bar,
   output logic [31:0]       addr_bar,
   input  logic [WIDTH-1:0]  data_out_bar,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [WIDTH-1:0]  m_data,
   output logic [1:0]        m_head,
   output logic [4:0]        m_row,
   output logic              m_last_row
`ifdef SOFTMAX_READER_CHECKSUM_EN
   ,
   output logic [31:0]       checksum
`endif
);

   import mhsa_pkg::*;

   localparam int unsigned CW = $clog2(NUM_WORDS + 1);
   localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;

   sm_state_e        state_q, state_d;
   logic [CW-1:0]    issue_cnt_q, issue_cnt_d;
   logic [CW-1:0]    pop_cnt_q, pop_cnt_d;
   logic             inflight_q, inflight_d;
   logic [31:0]      addr_q, addr_d;

   logic [WIDTH-1:0] fifo_rdata;
   logic             fifo_empty, fifo_full;
   logic [FW-1:0]    fifo_count;
   logic             credit_ok, issue, pop;

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (inflight_q),
      .wdata_i (data_out_bar),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .count_o (fifo_count)
   );

   // Buffered words plus the read in flight must fit, so a returning word always has a slot.
   assign credit_ok = !fifo_full && ((32'(fifo_count) + 32'(inflight_q)) < FIFO_DEPTH);
   assign issue     = (state_q == ST_FETCH) && (issue_cnt_q < CW'(NUM_WORDS)) && credit_ok;
   assign pop       = m_valid && m_ready;

   // addr_q always holds the next address to read, so the first read is on the bus right after start.
   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      pop_cnt_d   = pop_cnt_q;
      addr_d      = addr_q;
      inflight_d  = issue;
      if (pop) pop_cnt_d = pop_cnt_q + CW'(1);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_FETCH;
               issue_cnt_d = '0;
               pop_cnt_d   = '0;
               addr_d      = SOFTMAX_OUTPUT_BASE;
            end
         end
         ST_FETCH: begin
            if (issue) begin
               issue_cnt_d = issue_cnt_q + CW'(1);
               if (issue_cnt_q == CW'(NUM_WORDS - 1)) state_d = ST_DRAIN;
               else addr_d = SOFTMAX_OUTPUT_BASE + 32'(issue_cnt_q) + 32'd1;
            end
         end
         ST_DRAIN: begin
            if (pop && (pop_cnt_q == CW'(NUM_WORDS - 1))) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         issue_cnt_q <= '0;
         pop_cnt_q   <= '0;
         inflight_q  <= 1'b0;
         addr_q      <= SOFTMAX_OUTPUT_BASE;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         pop_cnt_q   <= pop_cnt_d;
         inflight_q  <= inflight_d;
         addr_q      <= addr_d;
      end
   end

   assign done         = (state_q == ST_DONE);
   assign busy         = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
   assign write_en_bar = 1'b0;
   assign data_in_bar  = '0;
   assign addr_bar     = addr_q;

   assign m_valid    = !fifo_empty;
   assign m_data     = fifo_empty ? '0 : fifo_rdata;
   assign m_head     = 2'(pop_cnt_q / CW'(WORDS_PER_ROW * ROWS_PER_HEAD));
   assign m_row      = 5'((pop_cnt_q / CW'(WORDS_PER_ROW)) % CW'(ROWS_PER_HEAD));
   assign m_last_row = ((pop_cnt_q % CW'(WORDS_PER_ROW)) == CW'(WORDS_PER_ROW - 1));

`ifdef SOFTMAX_READER_CHECKSUM_EN
   logic [31:0] csum_q, csum_d, pop_sum;

   always_comb begin
      pop_sum = '0;
      for (int unsigned b = 0; b < WIDTH / 8; b++) pop_sum = pop_sum + 32'(m_data[b*8 +: 8]);
   end

   always_comb begin
      csum_d = csum_q;
      if ((state_q == ST_IDLE) && start) csum_d = '0;
      else if (pop) csum_d = csum_q + pop_sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) csum_q <= '0;
      else        csum_q <= csum_d;
   end

   assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_softmax_reader.sv
// Self-checking bench for softmax_reader: scratch-memory model, stream monitor and reference model.
`timescale 1ns/1ps
module tb_softmax_reader;

   localparam int BASE  = 2560;
   localparam int NW    = 512;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        m_ready = 1'b0;
   logic [63:0] data_out_bar;
   logic        done, busy, write_en_bar, m_valid, m_last_row;
   logic [63:0] data_in_bar, m_data;
   logic [31:0] addr_bar;
   logic [1:0]  m_head;
   logic [4:0]  m_row;
`ifdef SOFTMAX_READER_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   softmax_reader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .done         (done),
      .busy         (busy),
      .write_en_bar (write_en_bar),
      .data_in_bar  (data_in_bar),
      .addr_bar     (addr_bar),
      .data_out_bar (data_out_bar),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_head       (m_head),
      .m_row        (m_row),
      .m_last_row   (m_last_row)
`ifdef SOFTMAX_READER_CHECKSUM_EN
      ,
      .checksum     (checksum)
`endif
   );

   always #5 clk = ~clk;

   logic [63:0] mem [0:4095];
   always @(posedge clk) data_out_bar <= mem[addr_bar[11:0]];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // reference model: stream word p is the p-th region word, tags by plain arithmetic
   function automatic logic [1:0] ref_head(int p); return 2'(p / 128); endfunction
   function automatic logic [4:0] ref_row(int p);  return 5'((p / 4) % 32); endfunction
   function automatic logic       ref_last(int p); return (p % 4) == 3; endfunction
   function automatic logic [31:0] ref_checksum();
      logic [31:0] s = 0;
      logic [63:0] w;
      for (int p = 0; p < NW; p++) begin
         w = mem[BASE + p];
         for (int b = 0; b < 8; b++) s = s + 32'(w[b*8 +: 8]);
      end
      return s;
   endfunction

   // stream monitor
   logic [63:0] got_data [NW];
   logic [1:0]  got_head [NW];
   logic [4:0]  got_row  [NW];
   logic        got_last [NW];
   int nbeats, done_cnt, done_cyc, first_valid_cyc, first_beat_cyc, last_beat_cyc;
   logic        prev_stall = 1'b0;
   logic [63:0] prev_data;
   logic [7:0]  prev_tags;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", m_valid, 1'b1);
            chk("stall_data", m_data, prev_data);
            chk("stall_tags", {m_head, m_row, m_last_row}, prev_tags);
         end
         chk("addr_range", (int'(addr_bar) >= BASE) && (int'(addr_bar) <= BASE + NW - 1), 1'b1);
         if (busy) chk("credit_lead", (int'(addr_bar) - BASE - nbeats) <= DEPTH, 1'b1);
         if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (m_valid && m_ready) begin
            if (nbeats < NW) begin
               got_data[nbeats] = m_data;
               got_head[nbeats] = m_head;
               got_row[nbeats]  = m_row;
               got_last[nbeats] = m_last_row;
            end
            if (nbeats == 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            nbeats++;
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_tags  = {m_head, m_row, m_last_row};
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_m_valid"}, m_valid, 1'b0);
      chk({tag, "_m_data"}, m_data, 64'd0);
      chk({tag, "_tags"}, {m_head, m_row, m_last_row}, 8'd0);
      chk({tag, "_addr"}, addr_bar, 32'(BASE));
      chk({tag, "_we"}, write_en_bar, 1'b0);
      chk({tag, "_din"}, data_in_bar, 64'd0);
`ifdef SOFTMAX_READER_CHECKSUM_EN
      chk({tag, "_checksum"}, checksum, 32'd0);
`endif
   endtask

   task automatic run_sweep(input string tag, input int ready_pct, input int poke_beat,
                            input int rst_beat, input bit timing);
      int  start_edge;
      bit  aborted, timeout, poked;
      aborted = 0; timeout = 1; poked = 0;
      nbeats = 0; done_cnt = 0; first_valid_cyc = -1;
      m_ready = (ready_pct >= 100);
      @(posedge clk); #1;
      start = 1'b1;
      start_edge = cyc + 1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 20000; k++) begin
         m_ready = ($urandom_range(0, 99) < ready_pct);
         start = 1'b0;
         if (poke_beat >= 0 && !poked && nbeats >= poke_beat) begin
            start = 1'b1;
            poked = 1;
         end
         if (rst_beat >= 0 && nbeats >= rst_beat) begin
            rst_n = 1'b0;
            start = 1'b0;
            #1;
            check_reset_outputs({tag, "_midreset"});
            @(posedge clk); @(posedge clk); #1;
            chk({tag, "_abort_no_done"}, done_cnt, 0);
            rst_n = 1'b1;
            aborted = 1; timeout = 0;
            break;
         end
         @(posedge clk); #1;
         if (done_cnt > 0) begin
            timeout = 0;
            break;
         end
      end
      start = 1'b0;
      if (timeout) chk({tag, "_timeout_done_seen"}, 1'b0, 1'b1);
      if (aborted || timeout) return;
      repeat (5) @(posedge clk);
      #1;
      chk({tag, "_beats"}, nbeats, NW);
      chk({tag, "_done_pulses"}, done_cnt, 1);
      for (int p = 0; p < NW && p < nbeats; p++) begin
         chk($sformatf("%s_data[%0d]", tag, p), got_data[p], mem[BASE + p]);
         chk($sformatf("%s_tags[%0d]", tag, p), {got_head[p], got_row[p], got_last[p]},
             {ref_head(p), ref_row(p), ref_last(p)});
      end
      if (timing) begin
         chk({tag, "_first_valid_latency"}, first_valid_cyc - start_edge, 2);
         chk({tag, "_no_bubbles"}, last_beat_cyc - first_beat_cyc, NW - 1);
         chk({tag, "_done_after_last"}, done_cyc - last_beat_cyc, 1);
      end
`ifdef SOFTMAX_READER_CHECKSUM_EN
      chk({tag, "_checksum"}, checksum, ref_checksum());
`endif
   endtask

   typedef struct {
      int         beat;
      logic [1:0] head;
      logic [4:0] row;
      logic       last;
   } tag_vec_t;
   tag_vec_t tag_tbl [6];

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tag_tbl[0] = '{0,   2'd0, 5'd0,  1'b0};
      tag_tbl[1] = '{3,   2'd0, 5'd0,  1'b1};
      tag_tbl[2] = '{4,   2'd0, 5'd1,  1'b0};
      tag_tbl[3] = '{127, 2'd0, 5'd31, 1'b1};
      tag_tbl[4] = '{128, 2'd1, 5'd0,  1'b0};
      tag_tbl[5] = '{511, 2'd3, 5'd31, 1'b1};

      for (int i = 0; i < 4096; i++) mem[i] = 64'hDEAD_0000_0000_0000 | 64'(i);
      for (int i = 0; i < NW; i++) mem[BASE + i] = 64'(i);

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      run_sweep("full_rate", 100, -1, -1, 1'b1);
      for (int t = 0; t < 6; t++)
         chk($sformatf("tag_table_beat%0d", tag_tbl[t].beat),
             {got_head[tag_tbl[t].beat], got_row[tag_tbl[t].beat], got_last[tag_tbl[t].beat]},
             {tag_tbl[t].head, tag_tbl[t].row, tag_tbl[t].last});

      run_sweep("ready30", 30, -1, -1, 1'b0);
      run_sweep("start_while_busy", 60, 100, -1, 1'b0);

      for (int i = 0; i < NW; i++) mem[BASE + i] = {$urandom, $urandom};
      run_sweep("reset_midsweep", 70, -1, 200, 1'b0);
      run_sweep("after_reset", 100, -1, -1, 1'b1);
      run_sweep("random_data", 45, -1, -1, 1'b0);

`ifdef SOFTMAX_READER_CHECKSUM_EN
      for (int i = 0; i < NW; i++) mem[BASE + i] = 64'h0101_0101_0101_0101;
      run_sweep("ones", 50, -1, -1, 1'b0);
      chk("checksum_all_ones", checksum, 32'd4096);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/softmax_reader.md
Name: softmax_reader

Overview:
Streams finished softmax probabilities from the shared scratch memory to the attention-value matmul stage. It sweeps the softmax output region of the memory bar with synchronous reads and buffers the words in a small credit-controlled FIFO. Words leave on a valid/ready stream tagged with head, row and end-of-row markers. It is the read-side counterpart of the softmax layer's write sweep.

Parameters:
WIDTH, 64, memory and stream word width in bits
SOFTMAX_OUTPUT_BASE, 2560, first word address of the softmax output region
NUM_WORDS, 512, words per sweep (4 heads x 32 rows x 4 words)
WORDS_PER_ROW, 4, 64-bit words per score row (32 x 8 bit)
ROWS_PER_HEAD, 32, rows per attention head
FIFO_DEPTH, 4, output buffer entries (power of two, >= 2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle sweep request; ignored unless IDLE
done  out  1  one-cycle pulse after the last word is accepted downstream
busy  out  1  high in FETCH and DRAIN
write_en_bar  out  1  tied 0 (read-only master)
data_in_bar  out  WIDTH  tied 0
addr_bar  out  32  memory read address
data_out_bar  in  WIDTH  read data, valid one cycle after addr_bar
m_valid  out  1  stream word available
m_ready  in  1  downstream accept
m_data  out  WIDTH  stream word (FIFO head)
m_head  out  2  head index of m_data
m_row  out  5  row index within head
m_last_row  out  1  m_data is the last word of its row

Behaviour:
- Reset values: done=0, busy=0, m_valid=0, m_data=0, tags=0, addr_bar=SOFTMAX_OUTPUT_BASE. All counters, FIFO pointers and the in-flight flag clear. The state is IDLE.
- The FSM has four states: IDLE, FETCH, DRAIN and DONE.
  - IDLE -> FETCH on start.
  - FETCH -> DRAIN in the cycle the NUM_WORDS-th read issues.
  - DRAIN -> DONE when the pop count reaches NUM_WORDS.
  - DONE -> IDLE after one cycle; done=1 only in DONE.
- Read issue happens in FETCH when issue_cnt < NUM_WORDS and occupancy + inflight < FIFO_DEPTH (credit rule).
  - On issue: addr_bar = SOFTMAX_OUTPUT_BASE + issue_cnt (registered), issue_cnt++ and inflight is set.
  - With no issue, addr_bar holds its value and inflight clears.
- Return path: data_out_bar is pushed into the FIFO on the edge after the issue cycle (inflight==1). A push can never find the FIFO full; the credit rule guarantees this.
- Latency: start sampled at edge E0 gives the first addr_bar in the cycle after E0. The push happens at E2 and m_valid rises after E2.
- Sustained throughput is 1 word/cycle while m_ready=1.
- Stream: m_valid = FIFO not empty. A word pops on m_valid & m_ready. m_data and tags are stable while m_valid & !m_ready.
- Tags come from pop index p (0..NUM_WORDS-1):
  - m_last_row = (p % WORDS_PER_ROW == WORDS_PER_ROW-1)
  - m_row = (p / WORDS_PER_ROW) % ROWS_PER_HEAD
  - m_head = p / (WORDS_PER_ROW*ROWS_PER_HEAD)
- Simultaneous push and pop in the same cycle leaves occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.
- issue_cnt and pop_cnt never exceed NUM_WORDS; no address outside [BASE, BASE+NUM_WORDS-1] is ever driven.
- A start while busy or in DONE is ignored with no restart. A new start in IDLE re-sweeps from BASE.
- Reset mid-sweep aborts immediately: FIFO contents are discarded and no done pulse is produced.

Optional Feature:
SOFTMAX_READER_CHECKSUM_EN:
- Defined: adds output port checksum [31:0]. It accumulates the wrap-around sum of all eight unsigned bytes of every popped word. It clears on reset and on accepted start, and holds its value from DONE until the next start.
- Undefined: the port and accumulator are absent and behaviour is otherwise identical.

Decomposition:
- Shared package mhsa_pkg holds the memory map constants (QKMM_OUTPUT_BASE, LINEAR_OUTPUT_BASE/SIZE, SOFTMAX_OUTPUT_BASE), the geometry constants (heads=4, seq=32, bytes per word=8) and the FSM state enum type.
- One sub-module, sync_fifo (parameterised WIDTH/DEPTH, push/pop/empty/full/count), holds the buffer. The FSM, credit logic and tag counters stay in the top.

Test Plan:
- Preload mem[2560+i]=i for i=0..511, start, m_ready=1:
  - 512 beats, m_data=i in order, first m_valid 3 edges after start.
  - No bubbles after the first beat; done one pulse after beat 511.
- Same preload, m_ready random 30% duty:
  - Data identical and in order; m_data stable during stall.
  - addr_bar never advances when occupancy+inflight = 4; no lost or duplicate words.
- Tag check on beats 0, 3, 4, 127, 128, 511:
  - (head,row,last) = (0,0,0), (0,0,1), (0,1,0), (0,31,1), (1,0,0), (3,31,1).
- Pulse start at beat 100 while busy -> ignored; sweep completes with exactly 512 beats and one done.
- Assert rst_n low at beat 200:
  - All outputs return to reset values, state IDLE, no done.
  - A following start streams from word 0 again.
- With SOFTMAX_READER_CHECKSUM_EN and every byte = 0x01 -> checksum = 4096 after done.
